// File: rtl/qspi_flash_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : qspi_pkg
// Brief  : Opcodes, status bit positions and FSM encoding for the QSPI flash
//          responder and the benches that talk to it.
// Rev    : 1.0 - initial release
// ============================================================================
package qspi_pkg;

  localparam logic [7:0] c_op_wren   = 8'h06;
  localparam logic [7:0] c_op_wrdi   = 8'h04;
  localparam logic [7:0] c_op_rdsr   = 8'h05;
  localparam logic [7:0] c_op_read   = 8'h03;
  localparam logic [7:0] c_op_qoread = 8'h6B;
  localparam logic [7:0] c_op_pp     = 8'h02;
  localparam logic [7:0] c_op_qpp    = 8'h32;
  localparam logic [7:0] c_op_se     = 8'h20;

  localparam int c_sts_wip = 0;
  localparam int c_sts_wel = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_STATUS = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_DUMMY  = 3'd6,
    ST_IGNORE = 3'd7
  } qspi_state_t;

endpackage
`default_nettype wire

// File: rtl/qspi_flash_responder_if.sv
`default_nettype none
// ============================================================================
// Module : qspi_flash_responder_if
// Brief  : QSPI pad bundle between initiator (master) and flash responder (slave).
// Rev    : 1.0 - initial release
// ============================================================================
interface qspi_flash_responder_if;
  logic       in_qspi_sck;
  logic       in_qspi_cs;
  logic [3:0] in_qspi_data;
  logic [3:0] out_qspi_data;
  logic [3:0] out_qspi_oe;

  modport master (
    output in_qspi_sck, in_qspi_cs, in_qspi_data,
    input  out_qspi_data, out_qspi_oe
  );

  modport slave (
    input  in_qspi_sck, in_qspi_cs, in_qspi_data,
    output out_qspi_data, out_qspi_oe
  );
endinterface
`default_nettype wire

// File: rtl/qspi_flash_responder_pin_sync.sv
`default_nettype none
// ============================================================================
// Module : qspi_pin_sync
// Brief  : 2-FF synchroniser for SCK/CS/IO with SCK and CS edge strobes.
// Rev    : 1.0 - initial release
// ============================================================================
module qspi_pin_sync (
  input  wire logic       i_clk,
  input  wire logic       i_reset,
  input  wire logic       i_sck,
  input  wire logic       i_cs,
  input  wire logic [3:0] i_data,
  output logic      [3:0] o_data,
  output logic            o_sck_rise,
  output logic            o_sck_fall,
  output logic            o_cs_rise,
  output logic            o_cs_fall
);
  logic [2:0] r_sck;
  logic [2:0] r_cs;
  logic [3:0] r_d1;
  logic [3:0] r_d2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck <= 3'b000;
      r_cs  <= 3'b111;
      r_d1  <= 4'h0;
      r_d2  <= 4'h0;
    end else begin
      r_sck <= {r_sck[1:0], i_sck};
      r_cs  <= {r_cs[1:0], i_cs};
      r_d1  <= i_data;
      r_d2  <= r_d1;
    end
  end

  // Strobes come from the second sync stage so data and edges stay aligned.
  assign o_data     = r_d2;
  assign o_sck_rise =  r_sck[1] & ~r_sck[2];
  assign o_sck_fall = ~r_sck[1] &  r_sck[2];
  assign o_cs_rise  =  r_cs[1]  & ~r_cs[2];
  assign o_cs_fall  = ~r_cs[1]  &  r_cs[2];
endmodule
`default_nettype wire

// File: rtl/qspi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module : qspi_flash_responder
// Brief  : QSPI flash-device stand-in: decodes WREN/WRDI/RDSR/READ/QOREAD/PP/QPP/SE
//          and serves an erasable, programmable byte array.
// Rev    : 1.0 - initial release
// ============================================================================
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int MEM_BYTES    = 65536,
  parameter int SECTOR_BYTES = 4096,
  parameter int PAGE_BYTES   = 256,
  parameter int PROG_CYCLES  = 64
) (
  input  wire logic            i_clk,
  input  wire logic            i_reset,
  qspi_flash_responder_if.slave bus,
  output logic                 out_wip,
  output logic                 out_wel
);
  localparam int c_aw  = $clog2(MEM_BYTES);
  localparam int c_sw  = $clog2(SECTOR_BYTES);
  localparam int c_pw  = $clog2(PAGE_BYTES);
  localparam int c_pcw = $clog2(PROG_CYCLES + 1);

  logic [3:0] w_din;
  logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

  qspi_pin_sync u_sync (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sck      (bus.in_qspi_sck),
    .i_cs       (bus.in_qspi_cs),
    .i_data     (bus.in_qspi_data),
    .o_data     (w_din),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_rise  (w_cs_rise),
    .o_cs_fall  (w_cs_fall)
  );

  qspi_state_t      r_state;
  logic [4:0]       r_bitcnt;
  logic [5:0]       r_total;
  logic [7:0]       r_shift, r_op, r_out_sh;
  logic [23:0]      r_addr;
  logic             r_op_ok, r_quad, r_wrote, r_wel, r_wip, r_erasing;
  logic [3:0]       r_dout, r_oe;
  logic [c_aw-1:0]  r_erase_addr;
  logic [c_pcw-1:0] r_prog_cnt;
  logic [7:0]       r_mem [MEM_BYTES];

  logic [7:0]       w_op, w_rd_byte, w_status, w_ld_byte, w_din_byte, w_mem_wdata;
  logic             w_byte_done, w_mem_we;
  logic [c_aw-1:0]  w_mem_addr;

  assign w_op      = {r_shift[6:0], w_din[0]};
  assign w_rd_byte = r_mem[r_addr[c_aw-1:0]];

  always_comb begin
    w_status            = 8'h00;
    w_status[c_sts_wip] = r_wip;
    w_status[c_sts_wel] = r_wel;
    w_ld_byte           = (r_state == ST_STATUS) ? w_status : w_rd_byte;
    w_din_byte          = r_quad ? {r_shift[3:0], w_din} : {r_shift[6:0], w_din[0]};
    w_byte_done         = r_quad ? (r_bitcnt == 5'd1) : (r_bitcnt == 5'd7);
    // Erase owns the port; PP cannot be accepted while wip=1, so no collision.
    w_mem_we    = r_erasing | ((r_state == ST_WDATA) & w_sck_rise & w_byte_done & ~w_cs_rise);
    w_mem_addr  = r_erasing ? r_erase_addr : r_addr[c_aw-1:0];
    w_mem_wdata = r_erasing ? 8'hFF : (w_rd_byte & w_din_byte);
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;   r_bitcnt <= 5'd0;  r_total <= 6'd0;
      r_shift <= 8'h00;     r_op <= 8'h00;     r_out_sh <= 8'h00;
      r_addr <= 24'h0;      r_op_ok <= 1'b0;   r_quad <= 1'b0;
      r_wrote <= 1'b0;      r_wel <= 1'b0;     r_wip <= 1'b0;
      r_erasing <= 1'b0;    r_dout <= 4'h0;    r_oe <= 4'h0;
      r_erase_addr <= '0;   r_prog_cnt <= '0;
    end else begin
      if (r_erasing) begin
        r_erase_addr <= r_erase_addr + 1'b1;
        if (&r_erase_addr[c_sw-1:0]) begin
          r_erasing <= 1'b0;
          r_wip     <= 1'b0;
        end
      end
      if (r_prog_cnt != '0) begin
        r_prog_cnt <= r_prog_cnt - 1'b1;
        if (r_prog_cnt == c_pcw'(1)) r_wip <= 1'b0;
      end

      if (w_cs_rise) begin
        r_state <= ST_IDLE;
        r_oe    <= 4'h0;
        r_dout  <= 4'h0;
        if (r_op_ok) begin
          case (r_op)
            c_op_wren: if (r_total == 6'd8) r_wel <= 1'b1;
            c_op_wrdi: if (r_total == 6'd8) r_wel <= 1'b0;
            c_op_pp, c_op_qpp: begin
              r_wel <= 1'b0;
              if (r_wrote) begin
                r_wip      <= 1'b1;
                r_prog_cnt <= c_pcw'(PROG_CYCLES);
              end
            end
            c_op_se: begin
              r_wel <= 1'b0;
              if (r_total == 6'd32) begin
                r_wip        <= 1'b1;
                r_erasing    <= 1'b1;
                r_erase_addr <= r_addr[c_aw-1:0] & ~c_aw'(SECTOR_BYTES - 1);
              end
            end
            default: ;
          endcase
        end
      end else begin
        if (w_sck_rise && r_state != ST_IDLE && r_total != 6'h3F) r_total <= r_total + 1'b1;
        case (r_state)
          ST_IDLE: if (w_cs_fall) begin
            r_state <= ST_CMD;  r_bitcnt <= 5'd0; r_total <= 6'd0;
            r_op_ok <= 1'b0;    r_quad <= 1'b0;   r_wrote <= 1'b0;
          end
          ST_CMD: if (w_sck_rise) begin
            r_shift  <= w_op;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 5'd7) begin
              r_op     <= w_op;
              r_bitcnt <= 5'd0;
              r_state  <= ST_IGNORE;
              if (!r_wip || w_op == c_op_rdsr) begin
                case (w_op)
                  c_op_rdsr:              r_state <= ST_STATUS;
                  c_op_wren, c_op_wrdi:   r_op_ok <= 1'b1;
                  c_op_read, c_op_qoread: begin r_state <= ST_ADDR; r_op_ok <= 1'b1; end
                  c_op_pp, c_op_qpp, c_op_se:
                    if (r_wel) begin r_state <= ST_ADDR; r_op_ok <= 1'b1; end
                  default: ;
                endcase
              end
            end
          end
          ST_ADDR: if (w_sck_rise) begin
            r_addr   <= {r_addr[22:0], w_din[0]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 5'd23) begin
              r_bitcnt <= 5'd0;
              case (r_op)
                c_op_read:   r_state <= ST_RDATA;
                c_op_qoread: begin r_state <= ST_DUMMY; r_quad <= 1'b1; end
                c_op_pp:     r_state <= ST_WDATA;
                c_op_qpp:    begin r_state <= ST_WDATA; r_quad <= 1'b1; end
                default:     r_state <= ST_IGNORE;
              endcase
            end
          end
          ST_DUMMY: if (w_sck_rise) begin
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 5'd7) begin
              r_bitcnt <= 5'd0;
              r_state  <= ST_RDATA;
            end
          end
          ST_STATUS, ST_RDATA: if (w_sck_fall) begin
            if (r_bitcnt == 5'd0) begin
              r_addr   <= r_addr + 1'b1;
              r_bitcnt <= 5'd1;
              if (r_quad) begin
                r_dout   <= w_ld_byte[7:4];
                r_out_sh <= {w_ld_byte[3:0], 4'h0};
                r_oe     <= 4'b1111;
              end else begin
                r_dout   <= {2'b00, w_ld_byte[7], 1'b0};
                r_out_sh <= {w_ld_byte[6:0], 1'b0};
                r_oe     <= 4'b0010;
              end
            end else if (r_quad) begin
              r_dout   <= r_out_sh[7:4];
              r_bitcnt <= 5'd0;
            end else begin
              r_dout   <= {2'b00, r_out_sh[7], 1'b0};
              r_out_sh <= {r_out_sh[6:0], 1'b0};
              r_bitcnt <= (r_bitcnt == 5'd7) ? 5'd0 : r_bitcnt + 1'b1;
            end
          end
          ST_WDATA: if (w_sck_rise) begin
            r_shift <= r_quad ? {r_shift[3:0], w_din} : {r_shift[6:0], w_din[0]};
            if (w_byte_done) begin
              r_bitcnt <= 5'd0;
              r_wrote  <= 1'b1;
              r_addr   <= {r_addr[23:c_pw], r_addr[c_pw-1:0] + 1'b1};
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.out_qspi_data = r_dout;
  assign bus.out_qspi_oe   = r_oe;
  assign out_wip           = r_wip;
  assign out_wel           = r_wel;
endmodule
`default_nettype wire

// File: tb/tb_qspi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_qspi_flash_responder
// Brief  : Directed bench driving the responder as a QSPI initiator.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_qspi_flash_responder;
  import qspi_pkg::*;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_wip, out_wel;
  logic [3:0] last_oe;
  int vectors = 0;
  int fails   = 0;

  qspi_flash_responder_if bus ();

  qspi_flash_responder dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus),
    .out_wip (out_wip),
    .out_wel (out_wel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q);
    bus.in_qspi_data = d;
    tick(HALF);
    bus.in_qspi_sck = 1'b1;
    q       = bus.out_qspi_data;
    last_oe = bus.out_qspi_oe;
    tick(HALF);
    bus.in_qspi_sck = 1'b0;
  endtask

  task automatic cs_start();
    bus.in_qspi_cs = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    bus.in_qspi_cs = 1'b1;
    tick(HALF);
  endtask

  task automatic tx1(input logic [7:0] b);
    logic [3:0] q;
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, q);
  endtask

  task automatic tx4(input logic [7:0] b);
    logic [3:0] q;
    sck_cycle(b[7:4], q);
    sck_cycle(b[3:0], q);
  endtask

  task automatic rx1(output logic [7:0] b);
    logic [3:0] q;
    for (int i = 7; i >= 0; i--) begin
      sck_cycle(4'h0, q);
      b[i] = q[1];
    end
  endtask

  task automatic rx4(output logic [7:0] b);
    logic [3:0] q;
    sck_cycle(4'h0, q);
    b[7:4] = q;
    sck_cycle(4'h0, q);
    b[3:0] = q;
  endtask

  task automatic tx_addr(input logic [23:0] a);
    tx1(a[23:16]);
    tx1(a[15:8]);
    tx1(a[7:0]);
  endtask

  task automatic cmd(input logic [7:0] op);
    cs_start();
    tx1(op);
    cs_end();
  endtask

  task automatic rdsr(output logic [7:0] s);
    cs_start();
    tx1(c_op_rdsr);
    rx1(s);
    cs_end();
  endtask

  task automatic rd(input logic [7:0] op, input logic [23:0] a, input int n, output logic [31:0] w);
    logic [7:0] b;
    logic [3:0] q;
    w = 32'h0;
    cs_start();
    tx1(op);
    tx_addr(a);
    if (op == c_op_qoread) for (int i = 0; i < 8; i++) sck_cycle(4'h0, q);
    for (int i = 0; i < n; i++) begin
      if (op == c_op_qoread) rx4(b); else rx1(b);
      w = {w[23:0], b};
    end
    cs_end();
  endtask

  task automatic prog(input logic [7:0] op, input logic [23:0] a, input int n, input logic [31:0] w);
    cs_start();
    tx1(op);
    tx_addr(a);
    for (int i = n - 1; i >= 0; i--) begin
      if (op == c_op_qpp) tx4(w[8*i +: 8]); else tx1(w[8*i +: 8]);
    end
    cs_end();
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (!out_wip) begin
        done = 1'b1;
        break;
      end
      tick(1);
    end
    chk({tag, "_idle"}, {31'b0, done}, 32'h1);
  endtask

  // Counts the i_clk cycles wip stays high after the SE command ends.
  task automatic erase(input logic [23:0] a, output int cnt);
    cmd(c_op_wren);
    cs_start();
    tx1(c_op_se);
    tx_addr(a);
    tick(HALF);
    bus.in_qspi_cs = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6000; i++) begin
      tick(1);
      if (out_wip) cnt++;
      else if (cnt > 0) break;
    end
    tick(HALF);
  endtask

  initial begin
    logic [7:0]  s;
    logic [31:0] w;
    logic [3:0]  q;
    int          cnt;

    bus.in_qspi_sck  = 1'b0;
    bus.in_qspi_cs   = 1'b1;
    bus.in_qspi_data = 4'h0;
    tick(4);
    rst = 1'b0;
    tick(4);

    chk("rst_oe", {28'b0, bus.out_qspi_oe}, 32'h0);
    chk("rst_data", {28'b0, bus.out_qspi_data}, 32'h0);
    chk("rst_wip", {31'b0, out_wip}, 32'h0);
    chk("rst_wel", {31'b0, out_wel}, 32'h0);
    rdsr(s);
    chk("rdsr_reset", {24'b0, s}, 32'h00);
    cmd(c_op_wren);
    chk("wren_wel", {31'b0, out_wel}, 32'h1);
    rdsr(s);
    chk("rdsr_wel", {24'b0, s}, 32'h02);

    erase(24'h00AA00, cnt);
    chk("se_wip_cycles", cnt, 32'd4096);
    chk("se_wel_clr", {31'b0, out_wel}, 32'h0);
    rdsr(s);
    chk("rdsr_after_se", {24'b0, s}, 32'h00);
    rd(c_op_read, 24'h00A000, 4, w);
    chk("se_base", w, 32'hFFFFFFFF);
    rd(c_op_read, 24'h00AFFE, 2, w);
    chk("se_top", w, 32'h0000FFFF);

    cmd(c_op_wren);
    prog(c_op_qpp, 24'h00AA00, 4, 32'h33333333);
    chk("qpp_wip", {31'b0, out_wip}, 32'h1);
    wait_idle("qpp");
    rd(c_op_read, 24'h00AA00, 4, w);
    chk("qpp_data", w, 32'h33333333);
    chk("read_oe", {28'b0, last_oe}, 32'h2);
    chk("qpp_wel_clr", {31'b0, out_wel}, 32'h0);

    prog(c_op_pp, 24'h00AA00, 4, 32'hFF00FF00);
    chk("pp_nowel_wip", {31'b0, out_wip}, 32'h0);
    rd(c_op_read, 24'h00AA00, 4, w);
    chk("pp_nowel_data", w, 32'h33333333);
    cmd(c_op_wren);
    prog(c_op_pp, 24'h00AA00, 4, 32'hFF00FF00);
    wait_idle("pp");
    rd(c_op_read, 24'h00AA00, 4, w);
    chk("pp_and", w, 32'h33003300);

    erase(24'h00F000, cnt);
    chk("se_f000_cycles", cnt, 32'd4096);
    erase(24'h000000, cnt);
    cmd(c_op_wren);
    prog(c_op_qpp, 24'h00FFFE, 2, 32'h00001234);
    wait_idle("qpp_fffe");
    cmd(c_op_wren);
    prog(c_op_qpp, 24'h000000, 2, 32'h00005678);
    wait_idle("qpp_0000");
    cmd(c_op_wren);
    prog(c_op_qpp, 24'h000FFF, 1, 32'h0000005A);
    wait_idle("qpp_0fff");
    rd(c_op_qoread, 24'h00FFFE, 4, w);
    chk("qoread_wrap", w, 32'h12345678);
    chk("qoread_oe", {28'b0, last_oe}, 32'hF);
    cmd(c_op_wren);
    prog(c_op_qpp, 24'h00AAFF, 3, 32'h00C5F00F);
    wait_idle("qpp_page");
    rd(c_op_read, 24'h00AAFF, 1, w);
    chk("page_aaff", w, 32'h000000C5);
    rd(c_op_read, 24'h00AA00, 4, w);
    chk("page_wrap", w, 32'h30003300);

    // SE cut short after 20 bits must not erase sector 0.
    cmd(c_op_wren);
    cs_start();
    tx1(c_op_se);
    tx1(8'h00);
    for (int i = 3; i >= 0; i--) sck_cycle({3'b000, 4'hA >> i}, q);
    cs_end();
    tick(20);
    chk("se20_wip", {31'b0, out_wip}, 32'h0);
    rd(c_op_read, 24'h000000, 2, w);
    chk("se20_data", w, 32'h00005678);

    cs_start();
    tx1(c_op_read);
    tx_addr(24'h00AA00);
    rx1(s);
    tick(HALF);
    chk("abort_oe_on", {28'b0, bus.out_qspi_oe}, 32'h2);
    bus.in_qspi_cs = 1'b1;
    tick(4);
    chk("abort_oe_off", {28'b0, bus.out_qspi_oe}, 32'h0);
    tick(HALF);

    cmd(c_op_wren);
    cs_start();
    tx1(c_op_se);
    tx_addr(24'h000000);
    tick(HALF);
    bus.in_qspi_cs = 1'b1;
    tick(200);
    chk("rst_erase_wip_on", {31'b0, out_wip}, 32'h1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("rst_erase_wip", {31'b0, out_wip}, 32'h0);
    chk("rst_erase_wel", {31'b0, out_wel}, 32'h0);
    chk("rst_erase_oe", {28'b0, bus.out_qspi_oe}, 32'h0);
    rdsr(s);
    chk("rst_erase_rdsr", {24'b0, s}, 32'h00);
    rd(c_op_read, 24'h000FFF, 1, w);
    chk("rst_erase_tail", w, 32'h0000005A);
    rd(c_op_read, 24'h000000, 2, w);
    chk("rst_erase_head", w, 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
`default_nettype wire
